// File: rtl/dsp_jtag_pkg.sv
// Shared types and constants for the FPGA-internal JTAG master driving the DSP scan chain.
package dsp_jtag_pkg;

  localparam int unsigned MAX_LEN = 32;
  localparam int unsigned LEN_W   = 6;

  localparam logic TMS_IDLE  = 1'b1;
  localparam logic TDI_IDLE  = 1'b0;
  localparam logic TRST_IDLE = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StLow,
    StHigh,
    StTrst,
    StDone
  } state_e;

  // Lengths above MAX_LEN shift a full word, so the bit counter can never wrap.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  endfunction

endpackage

// File: rtl/dsp_jtag_master_if.sv
// Host command/response bundle for the JTAG master: valid/ready command in, pulsed response out.
interface dsp_jtag_master_if;
  import dsp_jtag_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_trst;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_tms;
  logic [MAX_LEN-1:0] cmd_tdi;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_tdo;
  logic               busy;

  modport master (
    output cmd_valid, cmd_trst, cmd_len, cmd_tms, cmd_tdi,
    input  cmd_ready, rsp_valid, rsp_tdo, busy
  );

  modport slave (
    input  cmd_valid, cmd_trst, cmd_len, cmd_tms, cmd_tdi,
    output cmd_ready, rsp_valid, rsp_tdo, busy
  );

endinterface

// File: rtl/dsp_jtag_sync.sv
// Two-flop synchronizer bringing the chain's TDO into the CLK domain.
module dsp_jtag_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/dsp_jtag_master.sv
// JTAG master: shifts up to 32 TMS/TDI bits per host command into the DSP chain and
// returns the captured TDO vector; also issues timed TRST pulses.
module dsp_jtag_master
  import dsp_jtag_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned TRST_CYCLES = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  dsp_jtag_master_if.slave   cmd_if,
  output logic               o_jtag_tck,
  output logic               o_jtag_tms,
  output logic               o_jtag_tdi,
  input  logic               i_jtag_tdo,
  output logic               o_jtag_trst
);

  localparam int unsigned CNT_MAX = (CLK_DIV > TRST_CYCLES) ? CLK_DIV : TRST_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] TRST_LAST = CNT_W'(TRST_CYCLES - 1);

  state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [LEN_W-1:0]   r_idx, w_idx_nxt;
  logic [LEN_W-1:0]   r_len, w_len_nxt;
  logic [MAX_LEN-1:0] r_tms_vec, w_tms_vec_nxt;
  logic [MAX_LEN-1:0] r_tdi_vec, w_tdi_vec_nxt;
  logic               r_tck, w_tck_nxt;
  logic               r_tms, w_tms_nxt;
  logic               r_tdi, w_tdi_nxt;
  logic               r_trst, w_trst_nxt;
  logic               r_ready, w_ready_nxt;
  logic               r_rsp_valid, w_rsp_valid_nxt;
  logic [MAX_LEN-1:0] r_rsp_tdo, w_rsp_tdo_nxt;
  logic               r_busy, w_busy_nxt;

  logic               w_tdo_sync;
  logic               w_last_div;
  logic [LEN_W-1:0]   w_len_clamped;

  dsp_jtag_sync u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_jtag_tdo),
    .o_q   (w_tdo_sync)
  );

  assign w_last_div    = (r_cnt == DIV_LAST);
  assign w_len_clamped = clamp_len(cmd_if.cmd_len);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt + CNT_W'(1);
    w_idx_nxt       = r_idx;
    w_len_nxt       = r_len;
    w_tms_vec_nxt   = r_tms_vec;
    w_tdi_vec_nxt   = r_tdi_vec;
    w_tck_nxt       = r_tck;
    w_tms_nxt       = r_tms;
    w_tdi_nxt       = r_tdi;
    w_trst_nxt      = r_trst;
    w_ready_nxt     = r_ready;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_tdo_nxt   = r_rsp_tdo;
    w_busy_nxt      = r_busy;

    unique case (r_state)
      StIdle: begin
        w_ready_nxt = 1'b1;
        w_cnt_nxt   = '0;
        if (cmd_if.cmd_valid && r_ready) begin
          w_ready_nxt   = 1'b0;
          w_busy_nxt    = 1'b1;
          w_rsp_tdo_nxt = '0;
          w_idx_nxt     = '0;
          w_len_nxt     = w_len_clamped;
          w_tms_vec_nxt = cmd_if.cmd_tms;
          w_tdi_vec_nxt = cmd_if.cmd_tdi;
          if (cmd_if.cmd_trst) begin
            w_state_nxt = StTrst;
            w_trst_nxt  = 1'b0;
            w_tms_nxt   = TMS_IDLE;
            w_tck_nxt   = 1'b0;
          end else if (w_len_clamped == '0) begin
            w_state_nxt     = StDone;
            w_rsp_valid_nxt = 1'b1;
          end else begin
            w_state_nxt = StLow;
            w_tms_nxt   = cmd_if.cmd_tms[0];
            w_tdi_nxt   = cmd_if.cmd_tdi[0];
            w_tck_nxt   = 1'b0;
          end
        end
      end

      StLow: begin
        if (w_last_div) begin
          w_state_nxt = StHigh;
          w_tck_nxt   = 1'b1;
          w_cnt_nxt   = '0;
        end
      end

      StHigh: begin
        if (w_last_div) begin
          // TDO settled after the previous falling edge; sample it just before TCK drops.
          w_rsp_tdo_nxt[r_idx[4:0]] = w_tdo_sync;
          w_tck_nxt                 = 1'b0;
          w_cnt_nxt                 = '0;
          if (r_idx == r_len - LEN_W'(1)) begin
            w_state_nxt     = StDone;
            w_rsp_valid_nxt = 1'b1;
          end else begin
            w_state_nxt = StLow;
            w_idx_nxt   = r_idx + LEN_W'(1);
            w_tms_nxt   = r_tms_vec[r_idx[4:0] + 5'd1];
            w_tdi_nxt   = r_tdi_vec[r_idx[4:0] + 5'd1];
          end
        end
      end

      StTrst: begin
        if (r_cnt == TRST_LAST) begin
          w_state_nxt     = StDone;
          w_trst_nxt      = TRST_IDLE;
          w_rsp_valid_nxt = 1'b1;
          w_cnt_nxt       = '0;
        end
      end

      StDone: begin
        w_state_nxt = StIdle;
        w_busy_nxt  = 1'b0;
        w_ready_nxt = 1'b1;
        w_cnt_nxt   = '0;
      end

      default: begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_len       <= '0;
      r_tms_vec   <= '0;
      r_tdi_vec   <= '0;
      r_tck       <= 1'b0;
      r_tms       <= TMS_IDLE;
      r_tdi       <= TDI_IDLE;
      r_trst      <= TRST_IDLE;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_tdo   <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_len       <= w_len_nxt;
      r_tms_vec   <= w_tms_vec_nxt;
      r_tdi_vec   <= w_tdi_vec_nxt;
      r_tck       <= w_tck_nxt;
      r_tms       <= w_tms_nxt;
      r_tdi       <= w_tdi_nxt;
      r_trst      <= w_trst_nxt;
      r_ready     <= w_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_tdo   <= w_rsp_tdo_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign o_jtag_tck       = r_tck;
  assign o_jtag_tms       = r_tms;
  assign o_jtag_tdi       = r_tdi;
  assign o_jtag_trst      = r_trst;
  assign cmd_if.cmd_ready = r_ready;
  assign cmd_if.rsp_valid = r_rsp_valid;
  assign cmd_if.rsp_tdo   = r_rsp_tdo;
  assign cmd_if.busy      = r_busy;

endmodule

// File: tb/tb_dsp_jtag_master.sv
// Randomized bench for dsp_jtag_master against a behavioural scan-chain model and timing rules.
module tb_dsp_jtag_master;

  localparam int unsigned CLK_DIV     = 4;
  localparam int unsigned TRST_CYCLES = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tck, tms, tdi, trst;
  logic tdo;

  dsp_jtag_master_if u_if ();

  dsp_jtag_master #(
    .CLK_DIV     (CLK_DIV),
    .TRST_CYCLES (TRST_CYCLES)
  ) u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .cmd_if      (u_if),
    .o_jtag_tck  (tck),
    .o_jtag_tms  (tms),
    .o_jtag_tdi  (tdi),
    .i_jtag_tdo  (tdo),
    .o_jtag_trst (trst)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] len_mask(input int n);
    if (n >= 32) return 32'hFFFF_FFFF;
    return (32'h1 << n) - 32'h1;
  endfunction

  // Scan-chain model: TDO updates only on TCK falling edges.
  // Pattern mode presents pat[k] after k falling edges; loopback mode is a 1-bit register.
  int          rise_total = 0;
  int          fall_total = 0;
  int          fall_base  = 0;
  bit          obs_tms [0:4095];
  bit          obs_tdi [0:4095];
  logic        lb_latch = 1'b0;
  logic        lb_reg   = 1'b0;
  bit          chain_lb = 1'b0;
  logic [63:0] chain_pat = '0;
  int          kdx;

  always @(posedge tck) begin
    obs_tms[rise_total % 4096] <= tms;
    obs_tdi[rise_total % 4096] <= tdi;
    lb_latch   <= tdi;
    rise_total <= rise_total + 1;
  end

  always @(negedge tck) begin
    fall_total <= fall_total + 1;
    lb_reg     <= lb_latch;
  end

  always_comb begin
    kdx = fall_total - fall_base;
    if (kdx < 0)  kdx = 0;
    if (kdx > 63) kdx = 63;
    tdo = chain_lb ? ((kdx == 0) ? 1'b0 : lb_reg) : chain_pat[kdx];
  end

  // Pulse-shape monitors.
  int hi_run = 0, bad_hi = 0, trst_run = 0, last_trst_run = 0, bad_trst = 0;

  always @(negedge clk) begin
    if (tck === 1'b1) begin
      hi_run <= hi_run + 1;
    end else begin
      if (hi_run != 0 && hi_run != int'(CLK_DIV)) bad_hi <= bad_hi + 1;
      hi_run <= 0;
    end
    if (trst === 1'b0) begin
      trst_run <= trst_run + 1;
      if (tck !== 1'b0 || tms !== 1'b1) bad_trst <= bad_trst + 1;
    end else begin
      if (trst_run != 0) last_trst_run <= trst_run;
      trst_run <= 0;
    end
  end

  task automatic drive_cmd(input bit t, input logic [5:0] len, input logic [31:0] vtms,
                           input logic [31:0] vtdi, input bit lb, input logic [31:0] pat);
    chain_lb          = lb;
    chain_pat         = {32'h0, pat};
    fall_base         = fall_total;
    u_if.cmd_trst     = t;
    u_if.cmd_len      = len;
    u_if.cmd_tms      = vtms;
    u_if.cmd_tdi      = vtdi;
    u_if.cmd_valid    = 1'b1;
  endtask

  // Waits for accept; returns 0 if the DUT never became ready.
  task automatic wait_accept(output bit ok);
    int w;
    w = 0;
    while (u_if.cmd_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    ok = (u_if.cmd_ready === 1'b1);
    if (!ok) begin
      check_eq("ready_wait", 32'(u_if.cmd_ready), 32'd1);
      u_if.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    u_if.cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input bit t, input logic [5:0] len, input logic [31:0] vtms,
                         input logic [31:0] vtdi, input bit lb, input logic [31:0] pat);
    int n, m, exp_m, rb, hb, trb;
    bit ok;
    logic [31:0] exp_tdo, otms, otdi;
    n   = t ? 0 : ((len > 6'd32) ? 32 : int'(len));
    rb  = rise_total;
    hb  = bad_hi;
    trb = bad_trst;
    drive_cmd(t, len, vtms, vtdi, lb, pat);
    wait_accept(ok);
    if (!ok) return;
    check_eq("busy_after_accept", 32'(u_if.busy), 32'd1);
    check_eq("ready_low_after_accept", 32'(u_if.cmd_ready), 32'd0);
    exp_m = t ? int'(TRST_CYCLES) : 2 * n * int'(CLK_DIV);
    m = 0;
    while (u_if.rsp_valid !== 1'b1 && m < exp_m + 8) begin
      @(negedge clk);
      m++;
    end
    check_eq("rsp_latency", 32'(m), 32'(exp_m));
    if (t)       exp_tdo = 32'h0;
    else if (lb) exp_tdo = (vtdi << 1) & len_mask(n);
    else         exp_tdo = pat & len_mask(n);
    check_eq("rsp_tdo", u_if.rsp_tdo, exp_tdo);
    @(negedge clk);
    check_eq("rsp_single_pulse", 32'(u_if.rsp_valid), 32'd0);
    check_eq("ready_return", 32'(u_if.cmd_ready), 32'd1);
    check_eq("busy_clear", 32'(u_if.busy), 32'd0);
    check_eq("rsp_tdo_held", u_if.rsp_tdo, exp_tdo);
    check_eq("tck_pulses", 32'(rise_total - rb), 32'(n));
    otms = '0;
    otdi = '0;
    for (int i = 0; i < n; i++) begin
      otms[i] = obs_tms[(rb + i) % 4096];
      otdi[i] = obs_tdi[(rb + i) % 4096];
    end
    check_eq("tms_at_rise", otms, vtms & len_mask(n));
    check_eq("tdi_at_rise", otdi, vtdi & len_mask(n));
    check_eq("tck_high_width", 32'(bad_hi - hb), 32'd0);
    if (t) begin
      check_eq("trst_low_cycles", 32'(last_trst_run), 32'(TRST_CYCLES));
      check_eq("trst_tck_tms", 32'(bad_trst - trb), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int k, rb;
    u_if.cmd_valid = 1'b0;
    u_if.cmd_trst  = 1'b0;
    u_if.cmd_len   = '0;
    u_if.cmd_tms   = '0;
    u_if.cmd_tdi   = '0;

    repeat (5) @(negedge clk);
    check_eq("rst_tck", 32'(tck), 32'd0);
    check_eq("rst_tms", 32'(tms), 32'd1);
    check_eq("rst_tdi", 32'(tdi), 32'd0);
    check_eq("rst_trst", 32'(trst), 32'd1);
    check_eq("rst_ready", 32'(u_if.cmd_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(u_if.rsp_valid), 32'd0);
    check_eq("rst_busy", 32'(u_if.busy), 32'd0);
    check_eq("rst_rsp_tdo", u_if.rsp_tdo, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", 32'(u_if.cmd_ready), 32'd1);

    run_cmd(1'b0, 6'd5,  32'h0000_001F, 32'h0000_0000, 1'b0, 32'h0000_000D);
    run_cmd(1'b0, 6'd32, 32'h0000_0000, 32'hA5A5_A5A5, 1'b1, 32'h0);
    run_cmd(1'b0, 6'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF);
    run_cmd(1'b0, 6'd40, $urandom,      $urandom,      1'b0, $urandom);
    run_cmd(1'b1, 6'd12, $urandom,      $urandom,      1'b0, $urandom);

    // Abandon a shift during bit 3 HIGH.
    rb = rise_total;
    drive_cmd(1'b0, 6'd8, $urandom, $urandom, 1'b0, $urandom);
    wait_accept(ok);
    k = 0;
    while (rise_total - rb < 4 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_eq("mid_reach_bit3", 32'(rise_total - rb), 32'd4);
    check_eq("mid_tck_high", 32'(tck), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_tck", 32'(tck), 32'd0);
    check_eq("mid_rst_tms", 32'(tms), 32'd1);
    check_eq("mid_rst_ready", 32'(u_if.cmd_ready), 32'd0);
    check_eq("mid_rst_busy", 32'(u_if.busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check_eq("mid_rst_no_rsp", 32'(u_if.rsp_valid), 32'd0);
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_ready_after_rst", 32'(u_if.cmd_ready), 32'd1);
    run_cmd(1'b0, 6'd7, $urandom, $urandom, 1'b1, $urandom);

    for (int it = 0; it < 16; it++) begin
      bit          rt;
      logic [5:0]  rl;
      rt = ($urandom_range(0, 7) == 0);
      rl = 6'($urandom_range(0, 40));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_cmd(rt, rl, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
